screen_painter: RTL and testbench
=================================

Name: screen_painter

Overview:
- Consumer of the title/end-screen flag interface (title1, title2, winend, loseend, titleoff). Turns the currently requested screen into a full-frame pixel sweep on the VGA adapter's x/y/colour/plot port.
- Reads the image from an external synchronous image ROM that has 1-cycle read latency.
- Each screen is painted exactly once per change of request. Returning to gameplay (titleoff) triggers one black clear, after which the VGA port is released to the game renderer.

Parameters:
- H_RES, 160, horizontal pixels per frame
- V_RES, 120, vertical pixels per frame
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- A_W, 15, ROM address width; must satisfy 2^A_W >= H_RES*V_RES
- C_W, 3, colour width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- title1  in  1  request title image A
- title2  in  1  request title image B (flash phase)
- winend  in  1  request win screen
- loseend  in  1  request lose screen
- titleoff  in  1  gameplay active; request clear then release
- rom_sel  out  2  image select: 0=title1, 1=title2, 2=win, 3=lose
- rom_addr  out  A_W  pixel index, y*H_RES+x
- rom_data  in  C_W  pixel colour, valid one cycle after rom_addr/rom_sel
- x  out  X_W  pixel x to VGA
- y  out  Y_W  pixel y to VGA
- colour  out  C_W  pixel colour to VGA
- plot  out  1  pixel write strobe
- busy  out  1  painter owns the VGA port
- done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Clock and reset: reset resetn, synchronous, active-low; clock clk.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, rom_addr=0, rom_sel=0, state=IDLE, painted=INVALID.
- Request decode, evaluated each cycle, priority high to low: winend -> WIN; loseend -> LOSE; title1 -> T1; title2 -> T2; otherwise -> CLEAR. titleoff alone and all-zero inputs both decode to CLEAR.
- Shared encodings: screen code INVALID=7, T1=0, T2=1, WIN=2, LOSE=3, CLEAR=4.
- IDLE:
  - If the decoded request differs from painted, latch it into target, zero the x/y/addr counters, and go to PAINT.
  - Otherwise stay in IDLE; busy=0.
- PAINT: one pixel issued per cycle.
  - rom_sel=target[1:0], rom_addr=counter.
  - x increments and wraps at H_RES-1; y increments on x wrap.
  - After issuing (H_RES-1, V_RES-1), go to FLUSH.
- Output stage: registered, one cycle behind issue.
  - On the edge after rom_data is valid: x, y = issued coordinates delayed one cycle; colour = rom_data, or 0 when target=CLEAR; plot=1.
  - First plot occurs 2 cycles after leaving IDLE.
  - plot stays high for exactly H_RES*V_RES consecutive cycles (19200 by default).
- FLUSH: emits the final pixel, then goes to DONE.
- DONE: done=1 for one cycle, painted<=target, plot=0, then back to IDLE.
- busy=1 from the cycle after IDLE exits through the DONE cycle inclusive.
- Request change mid-frame: no abort. The current frame completes, and the new request is picked up on the first IDLE cycle. Intermediate requests that come and go mid-frame are never painted.
- T1/T2 flashing: each flip causes one full repaint. The minimum flash period must exceed H_RES*V_RES+4 cycles; the flag source's flash interval satisfies this.
- After a CLEAR frame completes, painted=CLEAR and the port stays idle (plot=0) until a non-CLEAR request arrives.
- Reset mid-paint: plot=0 and busy=0 from the next cycle; painted=INVALID, so the first request after reset is always painted.
- Arithmetic:
  - rom_addr is a separate linear counter, not a multiply.
  - Widths: x is X_W bits, y is Y_W bits, counter is A_W bits; no overflow for the default parameters.

Decomposition:
- Shared package: screen code constants, H_RES/V_RES defaults, ROM select encodings. The same constants are used by the ROM mux and the flag FSM.
- One natural sub-module, pixel_sweep: the x/y/addr counter with start input, last-pixel flag and wrap logic. It is reusable by the gameplay clear logic.

Test Plan:
- After reset, title1=1 -> plot first rises at cycle 2; first pixel x=0,y=0 with colour = ROM T1 word 0; plot high for 19200 cycles; last pixel x=159,y=119; done pulses once; busy then drops.
- Hold title1 after that frame -> no further plot; busy=0 indefinitely.
- title1 to title2 at cycle 5000 of a T1 paint -> the T1 frame completes untouched; then a T2 frame starts (rom_sel=1); 2 done pulses in total.
- winend=1 and title1=1 together -> rom_sel=2; colour matches the WIN ROM image; the LOSE and title images are never read.
- titleoff=1 with all other flags 0, after a LOSE frame -> one 19200-pixel frame with colour=0 throughout; then idle; a later loseend repaints LOSE.
- resetn=0 at pixel 100 -> plot=0 next cycle; after release with title1 still 1 -> full repaint from x=0,y=0.

Source files
------------

// File: rtl/screen_painter_pkg.sv
// Shared definitions for the title/end-screen painter.
// Contents:
//   - default frame geometry and bus widths
//   - screen codes, which are shared with the ROM mux and the flag FSM
//   - ROM image-select encodings
//   - painter state encoding
//   - the request priority decoder
package screen_painter_pkg;

   localparam int H_RES_DEF = 160;
   localparam int V_RES_DEF = 120;
   localparam int X_W_DEF   = 8;
   localparam int Y_W_DEF   = 7;
   localparam int A_W_DEF   = 15;
   localparam int C_W_DEF   = 3;

   // The low two bits of a paintable screen code double as the ROM image select.
   typedef enum logic [2:0] {
      SCR_T1      = 3'd0,
      SCR_T2      = 3'd1,
      SCR_WIN     = 3'd2,
      SCR_LOSE    = 3'd3,
      SCR_CLEAR   = 3'd4,
      SCR_INVALID = 3'd7
   } screen_t;

   localparam logic [1:0] ROM_SEL_T1   = 2'd0;
   localparam logic [1:0] ROM_SEL_T2   = 2'd1;
   localparam logic [1:0] ROM_SEL_WIN  = 2'd2;
   localparam logic [1:0] ROM_SEL_LOSE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PAINT = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } paint_state_t;

   // Priority: winend > loseend > title1 > title2 > anything else (clear).
   function automatic screen_t decode_request(input logic title1, input logic title2,
                                              input logic winend, input logic loseend,
                                              input logic titleoff);
      screen_t r;
      if (winend)        r = SCR_WIN;
      else if (loseend)  r = SCR_LOSE;
      else if (title1)   r = SCR_T1;
      else if (title2)   r = SCR_T2;
      else if (titleoff) r = SCR_CLEAR;
      else               r = SCR_CLEAR;
      return r;
   endfunction

endpackage

// File: rtl/screen_painter_pixel_sweep.sv
// Raster sweep counter: x/y coordinates plus a linear pixel address.
// Ports:
//   clk, resetn - clock, synchronous active-low reset
//   start       - zero all counters (has priority over advance)
//   advance     - step to the next pixel in raster order
//   x, y, addr  - current pixel coordinates and linear index y*H_RES+x
//   last        - current pixel is (H_RES-1, V_RES-1)
module pixel_sweep
   import screen_painter_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int X_W   = X_W_DEF,
   parameter int Y_W   = Y_W_DEF,
   parameter int A_W   = A_W_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic           advance,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [A_W-1:0] addr,
   output logic           last
);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [A_W-1:0] a_q, a_d;
   logic           x_wrap;

   assign x_wrap = (x_q == X_W'(H_RES - 1));

   // Next-count logic.
   // The address is its own counter so that no y*H_RES multiply is needed.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      a_d = a_q;
      if (start) begin
         x_d = '0;
         y_d = '0;
         a_d = '0;
      end else if (advance) begin
         a_d = a_q + A_W'(1);
         if (x_wrap) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end else begin
         x_d = x_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_q <= '0;
         y_q <= '0;
         a_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         a_q <= a_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign addr = a_q;
   assign last = x_wrap && (y_q == Y_W'(V_RES - 1));

endmodule

// File: rtl/screen_painter.sv
// Paints the requested title/end screen once per change of request.
// Each pixel is read from a 1-cycle-latency image ROM and written to the VGA port.
// A clear request paints one black frame and then releases the VGA port.
// Ports:
//   clk, resetn             - clock, synchronous active-low reset
//   title1, title2,
//   winend, loseend,
//   titleoff                - screen request flags (priority decoded)
//   rom_sel, rom_addr       - ROM image select and pixel index
//   rom_data                - ROM pixel colour, valid one cycle after the address
//   x, y, colour, plot      - VGA pixel write port
//   busy                    - painter owns the VGA port
//   done                    - one-cycle pulse after the last pixel of a frame
module screen_painter
   import screen_painter_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int X_W   = X_W_DEF,
   parameter int Y_W   = Y_W_DEF,
   parameter int A_W   = A_W_DEF,
   parameter int C_W   = C_W_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           title1,
   input  logic           title2,
   input  logic           winend,
   input  logic           loseend,
   input  logic           titleoff,
   output logic [1:0]     rom_sel,
   output logic [A_W-1:0] rom_addr,
   input  logic [C_W-1:0] rom_data,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [C_W-1:0] colour,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   paint_state_t   state_q, state_d;
   screen_t        target_q, target_d;
   screen_t        painted_q, painted_d;
   screen_t        req_s;

   logic           sweep_start, sweep_advance, sweep_last;
   logic [X_W-1:0] sweep_x;
   logic [Y_W-1:0] sweep_y;

   // Issue-stage pipeline registers, aligned with the ROM read in flight.
   logic           v1_q, v1_d;
   logic [X_W-1:0] x1_q, x1_d;
   logic [Y_W-1:0] y1_q, y1_d;

   // Output registers.
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [C_W-1:0] colour_q, colour_d;
   logic           plot_q, plot_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   pixel_sweep #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .X_W   (X_W),
      .Y_W   (Y_W),
      .A_W   (A_W)
   ) u_sweep (
      .clk     (clk),
      .resetn  (resetn),
      .start   (sweep_start),
      .advance (sweep_advance),
      .x       (sweep_x),
      .y       (sweep_y),
      .addr    (rom_addr),
      .last    (sweep_last)
   );

   assign req_s = decode_request(title1, title2, winend, loseend, titleoff);

   // Frame sequencing: next state, sweep control and the painted-screen record.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      painted_d     = painted_q;
      sweep_start   = 1'b0;
      sweep_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s != painted_q) begin
               target_d    = req_s;
               sweep_start = 1'b1;
               state_d     = ST_PAINT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PAINT: begin
            // Hold the counter on the last pixel rather than wrapping y past V_RES.
            if (sweep_last) begin
               state_d = ST_FLUSH;
            end else begin
               sweep_advance = 1'b1;
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE: begin
            painted_d = target_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel pipeline.
   // The ROM word for the issued pixel arrives one cycle later.
   // The output stage therefore uses the coordinates delayed by one cycle.
   always_comb begin
      v1_d     = (state_q == ST_PAINT);
      x1_d     = sweep_x;
      y1_d     = sweep_y;
      plot_d   = v1_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      if (v1_q) begin
         x_d      = x1_q;
         y_d      = y1_q;
         colour_d = (target_q == SCR_CLEAR) ? '0 : rom_data;
      end else begin
         colour_d = colour_q;
      end
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_DONE);
   end

   // State, pipeline and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         target_q  <= SCR_T1;
         painted_q <= SCR_INVALID;
         v1_q      <= 1'b0;
         x1_q      <= '0;
         y1_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         painted_q <= painted_d;
         v1_q      <= v1_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rom_sel = target_q[1:0];
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;
   assign plot    = plot_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_screen_painter.sv
module tb_screen_painter;

   localparam int H    = 32;
   localparam int V    = 24;
   localparam int NPIX = H * V;
   localparam int X_W  = 8;
   localparam int Y_W  = 7;
   localparam int A_W  = 15;
   localparam int C_W  = 3;

   // Request vectors: {titleoff, loseend, winend, title2, title1}
   localparam logic [4:0] R_T1     = 5'b00001;
   localparam logic [4:0] R_T2     = 5'b00010;
   localparam logic [4:0] R_WIN_T1 = 5'b00101;
   localparam logic [4:0] R_LOSE   = 5'b01000;
   localparam logic [4:0] R_OFF    = 5'b10000;

   localparam logic [2:0] S_T1    = 3'd0;
   localparam logic [2:0] S_T2    = 3'd1;
   localparam logic [2:0] S_WIN   = 3'd2;
   localparam logic [2:0] S_LOSE  = 3'd3;
   localparam logic [2:0] S_CLEAR = 3'd4;

   logic           clk = 1'b0;
   logic           resetn;
   logic           title1, title2, winend, loseend, titleoff;
   logic [1:0]     rom_sel;
   logic [A_W-1:0] rom_addr;
   logic [C_W-1:0] rom_data;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [C_W-1:0] colour;
   logic           plot, busy, done;

   int compares   = 0;
   int mismatches = 0;
   int plot_total = 0;
   int done_total = 0;
   int salt [4];

   screen_painter #(
      .H_RES (H), .V_RES (V), .X_W (X_W), .Y_W (Y_W), .A_W (A_W), .C_W (C_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .title1   (title1),
      .title2   (title2),
      .winend   (winend),
      .loseend  (loseend),
      .titleoff (titleoff),
      .rom_sel  (rom_sel),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Pseudo-random image contents, distinct per image select.
   function automatic logic [2:0] rom_word(input logic [1:0] sel, input int addr);
      int h;
      h = addr * 37 + (addr >> 3) + salt[sel];
      return h[2:0] ^ h[6:4];
   endfunction

   // Synchronous image ROM with 1-cycle read latency.
   always @(posedge clk) rom_data <= rom_word(rom_sel, int'(rom_addr));

   // Counts plot and done cycles over the whole run.
   always @(negedge clk) begin
      if (plot === 1'b1) plot_total++;
      if (done === 1'b1) done_total++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         mismatches++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [4:0] r);
      {titleoff, loseend, winend, title2, title1} = r;
   endtask

   // Follows one frame from the first busy cycle.
   // A frame is NPIX consecutive plots in raster order, starting two cycles after busy rises.
   // It is followed by a done pulse with busy and plot low.
   // At plot index ev_at, either apply ev_req or assert reset and stop following.
   task automatic run_frame(input string tag, input logic [2:0] scr, input int ev_at,
                            input logic [4:0] ev_req, input bit ev_reset);
      int waited = 0;
      int bad    = 0;
      int ex, ey, ec;
      string first_bad = "none";
      while (busy !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " busy_rise"}, 32'(busy), 32'd1);
      if (busy !== 1'b1) return;
      check({tag, " plot_c0"}, 32'(plot), 32'd0);
      check({tag, " rom_sel"}, 32'(rom_sel), 32'(scr[1:0]));
      @(negedge clk);
      check({tag, " plot_c1"}, 32'(plot), 32'd0);
      @(negedge clk);
      for (int idx = 0; idx < NPIX; idx++) begin
         ex = idx % H;
         ey = idx / H;
         ec = (scr == S_CLEAR) ? 0 : int'(rom_word(scr[1:0], idx));
         if (plot !== 1'b1 || busy !== 1'b1 || int'(x) != ex || int'(y) != ey ||
             int'(colour) != ec || rom_sel !== scr[1:0]) begin
            if (bad == 0)
               first_bad = $sformatf("idx %0d plot %0b x %0d y %0d c %0d want x %0d y %0d c %0d",
                                     idx, plot, x, y, colour, ex, ey, ec);
            bad++;
         end
         if (idx == ev_at) begin
            if (ev_reset) begin
               resetn = 1'b0;
               @(negedge clk);
               check({tag, " reset_plot"}, 32'(plot), 32'd0);
               check({tag, " reset_busy"}, 32'(busy), 32'd0);
               check({tag, " pixels_before_reset"}, 32'(bad), 32'd0);
               resetn = 1'b1;
               return;
            end else begin
               set_req(ev_req);
            end
         end
         @(negedge clk);
      end
      compares++;
      assert (bad == 0) else begin
         mismatches++;
         $error("FAIL %s pixels: observed %0d bad pixels (first: %s) expected 0", tag, bad, first_bad);
      end
      check({tag, " plot_end"}, 32'(plot), 32'd0);
      check({tag, " done_pulse"}, 32'(done), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
   endtask

   // Confirms that nothing is painted for n cycles.
   task automatic idle_check(input string tag, input int n);
      int p0 = plot_total;
      int busy_seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen++;
      end
      check({tag, " idle_busy"}, 32'(busy_seen), 32'd0);
      check({tag, " idle_plot"}, 32'(plot_total - p0), 32'd0);
   endtask

   initial begin
      int d0;
      int ev;
      for (int i = 0; i < 4; i++) salt[i] = int'($urandom);
      resetn = 1'b0;
      set_req(R_T1);
      repeat (3) @(negedge clk);
      check("reset x", 32'(x), 32'd0);
      check("reset y", 32'(y), 32'd0);
      check("reset colour", 32'(colour), 32'd0);
      check("reset plot", 32'(plot), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset rom_addr", 32'(rom_addr), 32'd0);
      check("reset rom_sel", 32'(rom_sel), 32'd0);
      resetn = 1'b1;

      run_frame("t1_first", S_T1, -1, R_T1, 1'b0);
      idle_check("t1_hold", 300);

      set_req(R_T2);
      run_frame("t2", S_T2, -1, R_T2, 1'b0);

      d0 = done_total;
      set_req(R_T1);
      ev = int'($urandom_range(50, NPIX - 50));
      run_frame("t1_switched", S_T1, ev, R_T2, 1'b0);
      run_frame("t2_after_switch", S_T2, -1, R_T2, 1'b0);
      check("switch done_count", 32'(done_total - d0), 32'd2);

      set_req(R_WIN_T1);
      run_frame("win", S_WIN, -1, R_WIN_T1, 1'b0);

      set_req(R_LOSE);
      run_frame("lose", S_LOSE, -1, R_LOSE, 1'b0);

      set_req(R_OFF);
      run_frame("clear", S_CLEAR, -1, R_OFF, 1'b0);
      idle_check("clear_hold", 200);
      set_req(5'b00000);
      idle_check("zero_req_hold", 50);

      set_req(R_LOSE);
      run_frame("lose_again", S_LOSE, -1, R_LOSE, 1'b0);

      set_req(R_T1);
      run_frame("t1_reset", S_T1, 100, R_T1, 1'b1);
      run_frame("t1_after_reset", S_T1, -1, R_T1, 1'b0);
      idle_check("final_hold", 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
